// File: rtl/tlc_pkg.sv
// Shared types and default timing for the N-way traffic-light controller.
package tlc_pkg;

  typedef enum logic [1:0] {
    StAllRed = 2'b00,
    StGreen  = 2'b01,
    StYellow = 2'b10,
    StFlash  = 2'b11
  } tlc_state_e;

  localparam int unsigned DefNumWays = 4;
  localparam int unsigned DefCntW    = 8;
  localparam int unsigned DefGreenT  = 6;
  localparam int unsigned DefYellowT = 4;
  localparam int unsigned DefAllRedT = 2;
  localparam int unsigned DefWalkT   = 3;
  localparam int unsigned DefFlashT  = 2;

endpackage

// File: rtl/tlc_rr_pick.sv
// Round-robin next-way selector: first demanding way after i_cur_way, else i_cur_way+1.
module tlc_rr_pick #(
  parameter int unsigned NUM_WAYS = 4,
  parameter int unsigned WAY_W    = 2
) (
  input  logic [WAY_W-1:0]    i_cur_way,
  input  logic [NUM_WAYS-1:0] i_demand,
  output logic [WAY_W-1:0]    o_next_way
);

  logic [2*NUM_WAYS-1:0] w_dbl;
  logic [WAY_W:0]        w_shamt;
  logic [NUM_WAYS-1:0]   w_rot;
  logic [WAY_W-1:0]      w_off;

  assign w_dbl   = {i_demand, i_demand};
  assign w_shamt = {1'b0, i_cur_way} + (WAY_W+1)'(1);
  // Bit k of w_rot is the demand of way (cur+1+k) mod NUM_WAYS.
  assign w_rot   = NUM_WAYS'(w_dbl >> w_shamt);

  always_comb begin
    w_off = '0;
    for (int k = NUM_WAYS - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = WAY_W'(k);
    end
  end

  assign o_next_way = WAY_W'((int'(i_cur_way) + 1 + int'(w_off)) % NUM_WAYS);

endmodule

// File: rtl/tlc_nway.sv
// N-way traffic-light controller: demand-aware round robin, pedestrian WALK, flashing-yellow mode.
module tlc_nway
  import tlc_pkg::*;
#(
  parameter int unsigned NUM_WAYS = DefNumWays,
  parameter int unsigned CNT_W    = DefCntW,
  parameter int unsigned GREEN_T  = DefGreenT,
  parameter int unsigned YELLOW_T = DefYellowT,
  parameter int unsigned ALLRED_T = DefAllRedT,
  parameter int unsigned WALK_T   = DefWalkT,
  parameter int unsigned FLASH_T  = DefFlashT,
  localparam int unsigned WayW    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_WAYS-1:0] i_demand,
  input  logic [NUM_WAYS-1:0] i_ped_req,
  input  logic                i_flash_en,
  output logic [NUM_WAYS-1:0] o_red,
  output logic [NUM_WAYS-1:0] o_yellow,
  output logic [NUM_WAYS-1:0] o_green,
  output logic [NUM_WAYS-1:0] o_walk,
  output logic [WayW-1:0]     o_cur_way,
  output logic [NUM_WAYS-1:0] o_ped_pend
);

  localparam logic [CNT_W-1:0] GreenLast  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YellowLast = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AllRedLast = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] FlashLast  = CNT_W'(FLASH_T - 1);

  tlc_state_e          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [WayW-1:0]     r_cur_way;
  logic [NUM_WAYS-1:0] r_ped_pend;
  logic                r_walk_flag;
  logic                r_flash_ph;

  logic [WayW-1:0]     w_next_way;
  logic [NUM_WAYS-1:0] w_pend_set;
  logic [NUM_WAYS-1:0] w_next_mask;
  logic [NUM_WAYS-1:0] w_way_mask;
  logic                w_in_walk;

  tlc_rr_pick #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WayW)
  ) u_rr_pick (
    .i_cur_way  (r_cur_way),
    .i_demand   (i_demand),
    .o_next_way (w_next_way)
  );

  assign w_pend_set  = r_ped_pend | i_ped_req;
  assign w_next_mask = NUM_WAYS'(1) << w_next_way;
  assign w_way_mask  = NUM_WAYS'(1) << r_cur_way;
  assign w_in_walk   = ({1'b0, r_cnt} < (CNT_W+1)'(WALK_T));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StAllRed;
      r_cnt       <= '0;
      r_cur_way   <= WayW'(NUM_WAYS - 1);
      r_ped_pend  <= '0;
      r_walk_flag <= 1'b0;
      r_flash_ph  <= 1'b0;
    end else begin
      r_ped_pend <= w_pend_set;
      unique case (r_state)
        StAllRed: begin
          if (r_cnt == AllRedLast) begin
            r_cnt <= '0;
            if (i_flash_en) begin
              r_state    <= StFlash;
              r_flash_ph <= 1'b0;
            end else begin
              // A same-cycle request is folded into the walk flag and never left pending.
              r_state     <= StGreen;
              r_cur_way   <= w_next_way;
              r_walk_flag <= |(w_pend_set & w_next_mask);
              r_ped_pend  <= w_pend_set & ~w_next_mask;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StGreen: begin
          if (r_cnt == GreenLast || i_flash_en) begin
            r_state <= StYellow;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StYellow: begin
          if (r_cnt == YellowLast) begin
            r_state <= StAllRed;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StFlash: begin
          if (!i_flash_en) begin
            r_state <= StAllRed;
            r_cnt   <= '0;
          end else if (r_cnt == FlashLast) begin
            r_cnt      <= '0;
            r_flash_ph <= ~r_flash_ph;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    o_red    = '0;
    o_yellow = '0;
    o_green  = '0;
    o_walk   = '0;
    unique case (r_state)
      StAllRed: o_red = '1;
      StGreen: begin
        o_green = w_way_mask;
        o_red   = ~w_way_mask;
        if (r_walk_flag && w_in_walk) o_walk = w_way_mask;
      end
      StYellow: begin
        o_yellow = w_way_mask;
        o_red    = ~w_way_mask;
      end
      StFlash: o_yellow = r_flash_ph ? '0 : '1;
    endcase
  end

  assign o_cur_way  = r_cur_way;
  assign o_ped_pend = r_ped_pend;

endmodule

// File: tb/tb_tlc_nway.sv
// Scoreboard bench for tlc_nway: a cycle model queues expected outputs per edge.
module tb_tlc_nway;

  localparam int NW       = 4;
  localparam int GREEN_T  = 6;
  localparam int YELLOW_T = 4;
  localparam int ALLRED_T = 2;
  localparam int WALK_T   = 3;
  localparam int FLASH_T  = 2;

  logic          clk;
  logic          rst_n;
  logic [NW-1:0] demand;
  logic [NW-1:0] ped_req;
  logic          flash_en;
  logic [NW-1:0] red, yellow, green, walk, ped_pend;
  logic [1:0]    cur_way;

  tlc_nway #(
    .NUM_WAYS (NW),
    .CNT_W    (8),
    .GREEN_T  (GREEN_T),
    .YELLOW_T (YELLOW_T),
    .ALLRED_T (ALLRED_T),
    .WALK_T   (WALK_T),
    .FLASH_T  (FLASH_T)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_demand   (demand),
    .i_ped_req  (ped_req),
    .i_flash_en (flash_en),
    .o_red      (red),
    .o_yellow   (yellow),
    .o_green    (green),
    .o_walk     (walk),
    .o_cur_way  (cur_way),
    .o_ped_pend (ped_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: 0 all-red, 1 green, 2 yellow, 3 flash.
  int         m_st, m_cnt, m_way;
  logic [3:0] m_pend;
  logic       m_wflag, m_fon;

  function automatic int m_next(input logic [3:0] dem);
    logic [3:0] t;
    for (int k = 1; k <= NW; k++) begin
      t = dem >> ((m_way + k) % NW);
      if (t[0]) return (m_way + k) % NW;
    end
    return (m_way + 1) % NW;
  endfunction

  function automatic void model_step(input logic rs, input logic [3:0] dem,
                                     input logic [3:0] ped, input logic fl);
    logic [3:0] np;
    if (!rs) begin
      m_st = 0; m_cnt = 0; m_way = NW - 1; m_pend = '0; m_wflag = 1'b0; m_fon = 1'b1;
      return;
    end
    np = m_pend | ped;
    case (m_st)
      0: if (m_cnt == ALLRED_T - 1) begin
        m_cnt = 0;
        if (fl) begin
          m_st = 3; m_fon = 1'b1;
        end else begin
          m_way   = m_next(dem);
          m_st    = 1;
          m_wflag = |(np & (4'b0001 << m_way));
          np      = np & ~(4'b0001 << m_way);
        end
      end else m_cnt++;
      1: if (m_cnt == GREEN_T - 1 || fl) begin m_st = 2; m_cnt = 0; end else m_cnt++;
      2: if (m_cnt == YELLOW_T - 1) begin m_st = 0; m_cnt = 0; end else m_cnt++;
      default: if (!fl) begin
        m_st = 0; m_cnt = 0;
      end else if (m_cnt == FLASH_T - 1) begin
        m_cnt = 0; m_fon = ~m_fon;
      end else m_cnt++;
    endcase
    m_pend = np;
  endfunction

  function automatic logic [21:0] model_out();
    logic [3:0] r, y, g, w, m;
    m = 4'b0001 << m_way;
    r = '0; y = '0; g = '0; w = '0;
    case (m_st)
      0: r = 4'b1111;
      1: begin g = m; r = ~m; if (m_wflag && m_cnt < WALK_T) w = m; end
      2: begin y = m; r = ~m; end
      default: y = m_fon ? 4'b1111 : 4'b0000;
    endcase
    return {r, y, g, w, 2'(m_way), m_pend};
  endfunction

  logic [21:0] sb[$];
  logic [3:0]  prev_green = '0;

  // Drive one cycle, push the model's prediction, then compare after the edge.
  task automatic cyc(input logic rs, input logic [3:0] dem, input logic [3:0] ped, input logic fl);
    logic [21:0] exp_v;
    rst_n = rs; demand = dem; ped_req = ped; flash_en = fl;
    model_step(rs, dem, ped, fl);
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    exp_v = sb.pop_front();
    check_val("model", {10'd0, red, yellow, green, walk, cur_way, ped_pend}, {10'd0, exp_v});
    check_val("one_green", 32'($countones(green) <= 1), 32'd1);
    check_val("walk_wo_green", {28'd0, walk & ~green}, 32'd0);
    if (rs) check_val("green_to_red", {28'd0, prev_green & red}, 32'd0);
    prev_green = green;
  endtask

  initial begin
    int         wcount;
    logic [5:0] wpat;
    logic [3:0] rdem, rped;
    logic       rfl;
    rst_n = 1'b0; demand = '0; ped_req = '0; flash_en = 1'b0;

    // Reset and idle rotation
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    check_val("rst_red", {28'd0, red}, 32'hf);
    check_val("rst_way", {30'd0, cur_way}, 32'd3);
    check_val("rst_pend", {28'd0, ped_pend}, 32'd0);
    cyc(1, 0, 0, 0);
    check_val("idle_ar", {28'd0, red}, 32'hf);
    for (int i = 0; i < 6; i++) begin cyc(1, 0, 0, 0); check_val("idle_g0", {28'd0, green}, 32'h1); end
    for (int i = 0; i < 4; i++) begin cyc(1, 0, 0, 0); check_val("idle_y0", {28'd0, yellow}, 32'h1); end
    for (int i = 0; i < 2; i++) begin cyc(1, 0, 0, 0); check_val("idle_ar2", {28'd0, red}, 32'hf); end
    cyc(1, 0, 0, 0);
    check_val("idle_g1", {28'd0, green}, 32'h2);

    // Demand skip
    cyc(0, 0, 0, 0); cyc(1, 4'b1001, 0, 0); cyc(1, 4'b1001, 0, 0);
    check_val("skip_w0", {30'd0, cur_way}, 32'd0);
    repeat (11) cyc(1, 4'b1001, 0, 0);
    cyc(1, 4'b1001, 0, 0);
    check_val("skip_w3", {28'd0, green}, 32'h8);
    repeat (11) cyc(1, 4'b1001, 0, 0);
    cyc(1, 4'b1001, 0, 0);
    check_val("skip_back_w0", {28'd0, green}, 32'h1);

    // Pedestrian on way 2
    cyc(0, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    cyc(1, 0, 4'b0100, 0);
    check_val("ped_latch", {28'd0, ped_pend}, 32'h4);
    for (int i = 0; i < 22; i++) begin cyc(1, 0, 0, 0); check_val("ped_hold", {28'd0, ped_pend}, 32'h4); end
    wcount = 0; wpat = '0;
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 0, 0);
      if (i == 0) check_val("ped_clear", {28'd0, ped_pend}, 32'd0);
      check_val("ped_green2", {28'd0, green}, 32'h4);
      wpat[i] = walk[2];
      wcount += int'(walk[2]);
    end
    check_val("walk_pattern", {26'd0, wpat}, 32'h07);
    check_val("walk_count", 32'(wcount), 32'd3);

    // Flash entry and exit
    cyc(0, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin cyc(1, 0, 0, 1); check_val("fl_yel", {28'd0, yellow}, 32'h1); end
    for (int i = 0; i < 2; i++) begin cyc(1, 0, 0, 1); check_val("fl_ar", {28'd0, red}, 32'hf); end
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, 1);
      check_val("flash", {28'd0, yellow}, (i % 4 < 2) ? 32'hf : 32'h0);
      check_val("flash_red", {28'd0, red}, 32'd0);
    end
    for (int i = 0; i < 2; i++) begin cyc(1, 0, 0, 0); check_val("fl_exit_ar", {28'd0, red}, 32'hf); end
    cyc(1, 0, 0, 0);
    check_val("fl_resume", {28'd0, green}, 32'h2);

    // Mid-phase reset at YELLOW cnt 2
    cyc(0, 0, 0, 0); cyc(1, 0, 4'b1000, 0); cyc(1, 0, 0, 0);
    repeat (5) cyc(1, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0);
    check_val("mr_yel", {28'd0, yellow}, 32'h1);
    check_val("mr_pend", {28'd0, ped_pend}, 32'h8);
    cyc(0, 0, 0, 0);
    check_val("mr_red", {28'd0, red}, 32'hf);
    check_val("mr_way", {30'd0, cur_way}, 32'd3);
    check_val("mr_pend0", {28'd0, ped_pend}, 32'd0);

    // Random traffic
    rfl = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      rdem = 4'($urandom);
      rped = 4'($urandom) & 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 199) == 0) rfl = ~rfl;
      cyc(1, rdem, rped, rfl);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tlc_nway.md
# tlc_nway

Parametrised N-way traffic-light controller, successor to the single-approach `tlc` FSM. It sequences a programmable number of approaches through GREEN, YELLOW and ALL_RED clearance phases in demand-aware round-robin order. It also serves latched pedestrian requests with a WALK window and supports a safe flashing-yellow mode. It sits at the top of the intersection datapath, driving the lamp drivers directly from registered state.

## Interface
- `NUM_WAYS`, 4: number of approaches; must be at least 2.
- `CNT_W`, 8: phase-counter width; every `*_T` must be at most 2^CNT_W.
- `GREEN_T`, 6: GREEN duration in cycles; must be at least 1.
- `YELLOW_T`, 4: YELLOW duration in cycles; must be at least 1.
- `ALLRED_T`, 2: ALL_RED clearance duration in cycles; must be at least 1.
- `WALK_T`, 3: WALK duration in cycles, taken from the start of GREEN; must satisfy 1 ≤ WALK_T ≤ GREEN_T.
- `FLASH_T`, 2: half-period of the flashing yellow, in cycles.
- `clk`, input, 1: single clock; all logic is clocked on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `demand`, input, NUM_WAYS: vehicle presence per approach, level-sensitive.
- `ped_req`, input, NUM_WAYS: pedestrian request per approach; a one-cycle pulse is sufficient.
- `flash_en`, input, 1: requests flashing mode while high.
- `red`, output, NUM_WAYS: red lamp per approach.
- `yellow`, output, NUM_WAYS: yellow lamp per approach.
- `green`, output, NUM_WAYS: green lamp per approach.
- `walk`, output, NUM_WAYS: pedestrian WALK lamp per approach.
- `cur_way`, output, $clog2(NUM_WAYS): index of the approach currently served.
- `ped_pend`, output, NUM_WAYS: latched, not-yet-served pedestrian requests.

## Operation
- **States:** ALL_RED, GREEN, YELLOW, FLASH.
- **Phase counter:** `cnt` counts 0..T-1 within each phase. The phase ends on the cycle in which `cnt == T-1`. `cnt` returns to 0 on every state change.
- **ALL_RED:**
  - All `red` = 1; `green`, `yellow` and `walk` = 0.
  - At phase end, if `flash_en` = 1, go to FLASH.
  - Otherwise go to GREEN. `cur_way` becomes the first index after `cur_way`, in modulo-NUM_WAYS order, whose `demand` bit is 1.
  - If no approach has demand, `cur_way` becomes `cur_way+1`. The current way is re-selected only when it is the sole demanding way.
- **GREEN:**
  - `green[cur_way]` = 1; `red` = 1 on all other approaches.
  - `walk[cur_way]` = 1 while `cnt < WALK_T`, but only if the walk flag was captured on entry.
  - Go to YELLOW at phase end, or on the first cycle in which `flash_en` = 1, whichever comes first. A `flash_en` request truncates GREEN; it never truncates YELLOW or ALL_RED.
- **YELLOW:** `yellow[cur_way]` = 1; `red` = 1 on all others. Go to ALL_RED at phase end.
- **FLASH:**
  - `red`, `green` and `walk` all 0.
  - All `yellow` bits together are 1 for FLASH_T cycles, then 0 for FLASH_T cycles, repeating. The pattern starts with the lamps on.
  - When `flash_en` = 0, go to ALL_RED with `cnt` = 0; normal rotation then resumes.
- **Pedestrian latch:**
  - `ped_pend[i]` is set by `ped_req[i]`.
  - On the GREEN entry edge for way i, the walk flag is captured as `ped_pend[i] | ped_req[i]`, and `ped_pend[i]` clears on that same edge.
  - A request for way i that arrives while way i is already in GREEN or YELLOW stays pending until way i's next GREEN.
  - Pending requests persist through FLASH.
- **Lamp exclusivity:** exactly one of `red`, `yellow` or `green` is 1 per approach in every state except FLASH. At most one `green` bit is 1 at any time.

## Timing
- **Reset** (on a clock edge with `rst_n` = 0):
  - State ALL_RED, `cnt` = 0, `cur_way` = NUM_WAYS-1, `ped_pend` = 0, walk flag = 0.
  - Outputs: `red` all 1; `green`, `yellow` and `walk` = 0; `cur_way` = NUM_WAYS-1; `ped_pend` = 0.
  - Asserting reset mid-phase aborts the phase at the next edge. No YELLOW is inserted.
- **Output timing:** all outputs are a decode of registered state, `cnt`, `cur_way`, walk flag and `ped_pend`. There is no combinational path from any input to any output. A state change is visible in the same cycle the state register updates.
- **Input sampling:**
  - `demand` and `flash_en` are sampled only on the edge that ends a phase, except for the GREEN truncation rule above.
  - `flash_en` asserted during GREEN produces YELLOW after exactly 1 edge.
- **Normal cycle per served way:** GREEN_T + YELLOW_T + ALLRED_T cycles (12 with default parameters). The first GREEN begins ALLRED_T cycles after reset release.
- **Simultaneous events:**
  - Reset has priority over everything.
  - A `ped_req` in the same cycle as that way's GREEN entry is served in that GREEN.
  - `flash_en` rising in the same cycle that YELLOW ends has no effect until ALL_RED ends.

## Structure
- **Package `tlc_pkg`:** state enum (2-bit: ALL_RED=00, GREEN=01, YELLOW=10, FLASH=11) and the default timing constants.
- **Sub-module `tlc_rr_pick`:** combinational next-way selector. Inputs are `cur_way` and `demand`; output is the next index. Implemented as a rotate, priority-encode, un-rotate.
- **Top module:** the FSM, `cnt`, the flash phase bit, `ped_pend` and the output decode.

## Test plan
All scenarios use the default parameters.
- **Reset and idle rotation:** `rst_n` low for 2 cycles, `demand` = 4'b0000.
  - ALL_RED for 2 cycles.
  - `green` = 0001 for 6 cycles, then `yellow` = 0001 for 4, then ALL_RED for 2, then `green` = 0010.
- **Demand skip:** `demand` = 4'b1001 with `cur_way` = 0 at ALL_RED end → next GREEN on way 3, then way 0.
- **Pedestrian:** 1-cycle `ped_req[2]` while way 0 is GREEN.
  - `ped_pend` = 0100 until way 2 enters GREEN.
  - `walk[2]` = 1 for exactly 3 cycles, then 0 for the remaining 3 GREEN cycles.
  - `ped_pend` clears on the GREEN entry edge.
- **Flash entry/exit:** `flash_en` = 1 at GREEN `cnt` = 1.
  - Next cycle YELLOW for 4 cycles, then ALL_RED for 2.
  - Then `yellow` = 1111 for 2 cycles, 0000 for 2, repeating.
  - After `flash_en` drops: ALL_RED for 2, then GREEN on the next way.
- **Mid-phase reset:** `rst_n` = 0 at YELLOW `cnt` = 2 → next edge `red` = 1111, `cur_way` = 3, `ped_pend` = 0.
- **Exclusivity check:** random `demand`/`ped_req`/`flash_en` for 10k cycles. Assert at most one `green` bit, no `walk` without matching `green`, and never `green` directly followed by `red` on the same way.
